// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared constants and types for the instruction memory loader.
//   IMEM_ADDR_W    : instruction memory address width (matches the 8-bit PC)
//   INSTR_W        : instruction word width
//   IMEM_ADDR_STEP : byte address increment between consecutive words
//   IMEM_CNT_W     : width of the word counters
//   loader_state_t : loader FSM states
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_ADDR_W    = 8;
    localparam int INSTR_W        = 32;
    localparam int IMEM_ADDR_STEP = 4;
    localparam int IMEM_CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte stream handshake and the instruction memory write port.
//   in_valid / in_data / in_ready : byte stream (valid/ready)
//   wr_en / wr_addr / wr_data     : instruction memory write port
// Modports:
//   master : the side that supplies bytes and observes the write port
//   slave  : the loader, which consumes bytes and drives the write port
// -----------------------------------------------------------------------------
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);

    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/imem_word_packer.sv
// -----------------------------------------------------------------------------
// imem_word_packer
// Assembles four accepted bytes into one little-endian 32-bit word.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   clear      : synchronous restart, discards any partial word
//   byte_en    : a byte is accepted this cycle
//   byte_data  : the accepted byte
//   word_valid : high in the cycle the fourth byte is accepted
//   word       : assembled word, meaningful while word_valid is high
// Only the first three bytes are stored; the fourth is merged straight into
// the output so the word is available in the same cycle it completes.
// -----------------------------------------------------------------------------
module imem_word_packer
    import imem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byte_en,
    input  logic [7:0]         byte_data,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] assembly;

    // The fourth byte completes the word and lands in the top lane.
    assign word_valid = byte_en && (byte_idx == 2'd3);
    assign word       = {byte_data, assembly};

    // Byte lane steering: byte N goes to bits [8N+7:8N], first byte is the
    // LSB. The index wraps naturally from 3 back to 0 after a full word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            assembly <= 24'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            assembly <= 24'd0;
        end else if (byte_en) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    assembly[7:0]   <= byte_data;
                2'd1:    assembly[15:8]  <= byte_data;
                2'd2:    assembly[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program into instruction memory from a byte stream. Bytes are
// packed little-endian into 32-bit words and written at consecutive word
// addresses starting from base_addr. fetch_hold stays high for the whole
// load so the fetch stage never sees half-written program memory.
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   start         : begin a load (only honoured in IDLE)
//   abort         : synchronous cancel back to IDLE
//   base_addr     : first word address, latched on start
//   word_count    : number of words to load, latched on start
//   bus           : byte stream in + memory write port out (slave modport)
//   busy          : a load is in progress
//   fetch_hold    : same as busy, freezes PC and IF/ID
//   done          : one-cycle pulse on successful completion
//   words_written : words written by the current or last load
// All outputs are registered; in_ready does not depend on in_valid.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int ADDR_STEP = IMEM_ADDR_STEP,
    parameter int CNT_W     = IMEM_CNT_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    imem_loader_if.slave      bus,
    output logic              busy,
    output logic              fetch_hold,
    output logic              done,
    output logic [CNT_W-1:0]  words_written
);

    loader_state_t      state;
    loader_state_t      next_state;

    logic               in_ready_q;
    logic               wr_en_q;
    logic               busy_q;
    logic               done_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [INSTR_W-1:0] wr_data_q;

    logic [ADDR_W-1:0]  cur_addr;
    logic [CNT_W-1:0]   words_left;
    logic [CNT_W-1:0]   words_written_q;

    logic               byte_en;
    logic               packer_clear;
    logic               word_valid;
    logic [INSTR_W-1:0] packed_word;

    // A byte is consumed only on a real handshake; a byte offered in the
    // same cycle as abort is dropped along with the rest of the load.
    assign byte_en      = bus.in_valid && in_ready_q && !abort;
    assign packer_clear = (state == IDLE) || abort;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (packer_clear),
        .byte_en    (byte_en),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    // Next-state decode. Abort takes priority everywhere, including over a
    // simultaneous start in IDLE. WRITE always lasts exactly one cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!abort && start) begin
                    next_state = (word_count == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (word_valid) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    next_state = (words_left == CNT_W'(1)) ? DONE : RECV;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the upcoming state, so each
    // control output is a flop that already matches the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state == RECV);
            wr_en_q    <= (next_state == WRITE);
            busy_q     <= (next_state != IDLE);
            done_q     <= (next_state == DONE);
        end
    end

    // Address and word bookkeeping. The write address/data are captured as
    // the word completes; counters advance as WRITE exits. An abort during
    // WRITE still counts that word because its strobe is already on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr        <= '0;
            words_left      <= '0;
            words_written_q <= '0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        cur_addr        <= base_addr;
                        words_left      <= word_count;
                        words_written_q <= '0;
                    end
                end
                RECV: begin
                    if (word_valid) begin
                        wr_addr_q <= cur_addr;
                        wr_data_q <= packed_word;
                    end
                end
                WRITE: begin
                    cur_addr        <= cur_addr + ADDR_W'(ADDR_STEP);
                    words_left      <= words_left - CNT_W'(1);
                    words_written_q <= words_written_q + CNT_W'(1);
                end
                DONE: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign busy          = busy_q;
    assign fetch_hold    = busy_q;
    assign done          = done_q;
    assign words_written = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader: single word, stalled multi-word load,
// address wrap, zero count, abort with reload, asynchronous reset mid-load
// and start ignored while busy. Inputs change 2 ns after the rising edge,
// outputs are sampled at that same point (away from the edge).
// -----------------------------------------------------------------------------
module tb_imem_loader;
    import imem_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] base_addr = 8'd0;
    logic [7:0] word_count = 8'd0;
    logic       busy;
    logic       fetch_hold;
    logic       done;
    logic [7:0] words_written;

    int err_count = 0;
    int check_count = 0;
    int done_count = 0;
    int overlap_count = 0;
    logic [7:0]  log_addr[$];
    logic [31:0] log_data[$];

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .bus           (bus),
        .busy          (busy),
        .fetch_hold    (fetch_hold),
        .done          (done),
        .words_written (words_written)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Independent record of memory writes, done pulses and any cycle where
    // in_ready overlaps a write strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                log_addr.push_back(bus.wr_addr);
                log_data.push_back(bus.wr_data);
            end
            if (bus.wr_en && bus.in_ready) begin
                overlap_count++;
            end
            if (done) begin
                done_count++;
            end
        end
    end

    // Safety net in case a handshake never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic startLoad(input logic [7:0] base, input logic [7:0] count);
        start      = 1'b1;
        base_addr  = base;
        word_count = count;
        nextCycle();
        start = 1'b0;
    endtask

    // Offers one byte and holds it until the loader takes it. With stall set,
    // in_valid then drops for one cycle before the next byte.
    task automatic applyStimulus(input logic [7:0] data, input bit stall);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        while (!bus.in_ready && waited < 40) begin
            nextCycle();
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("byte_accept_timeout", 32'd0, 32'd1);
        end
        nextCycle();
        bus.in_valid = 1'b0;
        if (stall) begin
            nextCycle();
        end
    endtask

    task automatic sendWord(input logic [31:0] w, input bit stall);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(w[8*i +: 8], stall);
        end
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (!done && n < 100) begin
            nextCycle();
            n++;
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state
        #12;
        checkOutput("rst_busy",       {31'd0, busy},          32'd0);
        checkOutput("rst_fetch_hold", {31'd0, fetch_hold},    32'd0);
        checkOutput("rst_in_ready",   {31'd0, bus.in_ready},  32'd0);
        checkOutput("rst_wr_en",      {31'd0, bus.wr_en},     32'd0);
        checkOutput("rst_done",       {31'd0, done},          32'd0);
        checkOutput("rst_words",      {24'd0, words_written}, 32'd0);
        rst_n = 1'b1;
        nextCycle();

        // Single word, back-to-back bytes
        $display("[TB] single word");
        startLoad(8'h00, 8'd1);
        checkOutput("t1_fetch_hold", {31'd0, fetch_hold},   32'd1);
        checkOutput("t1_in_ready",   {31'd0, bus.in_ready}, 32'd1);
        applyStimulus(8'h13, 1'b0);
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h50, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t1_wr_en",     {31'd0, bus.wr_en},    32'd1);
        checkOutput("t1_wr_addr",   {24'd0, bus.wr_addr},  32'h00);
        checkOutput("t1_wr_data",   bus.wr_data,           32'h00500513);
        checkOutput("t1_ready_wr",  {31'd0, bus.in_ready}, 32'd0);
        nextCycle();
        checkOutput("t1_done",      {31'd0, done},          32'd1);
        checkOutput("t1_wr_en_off", {31'd0, bus.wr_en},     32'd0);
        checkOutput("t1_busy_done", {31'd0, busy},          32'd1);
        checkOutput("t1_words",     {24'd0, words_written}, 32'd1);
        nextCycle();
        checkOutput("t1_idle_busy", {31'd0, busy},       32'd0);
        checkOutput("t1_idle_hold", {31'd0, fetch_hold}, 32'd0);
        checkOutput("t1_done_off",  {31'd0, done},       32'd0);

        // Three words with a stalled source
        $display("[TB] three words, stalled source");
        log_addr.delete();
        log_data.delete();
        overlap_count = 0;
        startLoad(8'h10, 8'd3);
        checkOutput("t2_fetch_hold", {31'd0, fetch_hold}, 32'd1);
        sendWord(32'h11223344, 1'b1);
        checkOutput("t2_hold_mid", {31'd0, fetch_hold}, 32'd1);
        sendWord(32'hDEADBEEF, 1'b1);
        sendWord(32'h00000013, 1'b1);
        waitDone("t2_done");
        nextCycle();
        checkOutput("t2_hold_off",  {31'd0, fetch_hold},    32'd0);
        checkOutput("t2_words",     {24'd0, words_written}, 32'd3);
        checkOutput("t2_n_writes",  log_addr.size(),        32'd3);
        checkOutput("t2_overlap",   overlap_count,          32'd0);
        if (log_addr.size() == 3) begin
            checkOutput("t2_addr0", {24'd0, log_addr[0]}, 32'h10);
            checkOutput("t2_addr1", {24'd0, log_addr[1]}, 32'h14);
            checkOutput("t2_addr2", {24'd0, log_addr[2]}, 32'h18);
            checkOutput("t2_data0", log_data[0], 32'h11223344);
            checkOutput("t2_data1", log_data[1], 32'hDEADBEEF);
            checkOutput("t2_data2", log_data[2], 32'h00000013);
        end

        // Address wrap
        $display("[TB] address wrap");
        log_addr.delete();
        log_data.delete();
        startLoad(8'hFC, 8'd2);
        sendWord(32'hCAFEF00D, 1'b0);
        sendWord(32'h12345678, 1'b0);
        waitDone("t3_done");
        nextCycle();
        checkOutput("t3_n_writes", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            checkOutput("t3_addr0", {24'd0, log_addr[0]}, 32'hFC);
            checkOutput("t3_addr1", {24'd0, log_addr[1]}, 32'h00);
            checkOutput("t3_data0", log_data[0], 32'hCAFEF00D);
            checkOutput("t3_data1", log_data[1], 32'h12345678);
        end

        // Zero word count
        $display("[TB] zero count");
        log_addr.delete();
        log_data.delete();
        startLoad(8'h30, 8'd0);
        checkOutput("t4_done",     {31'd0, done},         32'd1);
        checkOutput("t4_busy",     {31'd0, busy},         32'd1);
        checkOutput("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("t4_wr_en",    {31'd0, bus.wr_en},    32'd0);
        nextCycle();
        checkOutput("t4_idle",     {31'd0, busy},         32'd0);
        checkOutput("t4_done_off", {31'd0, done},         32'd0);
        checkOutput("t4_words",    {24'd0, words_written}, 32'd0);
        checkOutput("t4_n_writes", log_addr.size(),       32'd0);

        // Abort after two bytes of the second word, then a clean reload
        $display("[TB] abort and reload");
        log_addr.delete();
        log_data.delete();
        done_count = 0;
        startLoad(8'h40, 8'd3);
        sendWord(32'h01020304, 1'b0);
        applyStimulus(8'hEE, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        abort = 1'b1;
        nextCycle();
        abort = 1'b0;
        checkOutput("t5_busy",     {31'd0, busy},         32'd0);
        checkOutput("t5_in_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (3) nextCycle();
        checkOutput("t5_no_done",  done_count,            32'd0);
        checkOutput("t5_words",    {24'd0, words_written}, 32'd1);
        checkOutput("t5_n_writes", log_addr.size(),       32'd1);
        startLoad(8'h80, 8'd1);
        sendWord(32'hDDCCBBAA, 1'b0);
        checkOutput("t5_re_wr_en",   {31'd0, bus.wr_en},   32'd1);
        checkOutput("t5_re_wr_addr", {24'd0, bus.wr_addr}, 32'h80);
        checkOutput("t5_re_wr_data", bus.wr_data,          32'hDDCCBBAA);
        nextCycle();
        checkOutput("t5_re_done",  {31'd0, done},          32'd1);
        checkOutput("t5_re_words", {24'd0, words_written}, 32'd1);
        nextCycle();

        // Asynchronous reset mid-RECV
        $display("[TB] async reset mid-load");
        startLoad(8'h50, 8'd2);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_busy",     {31'd0, busy},         32'd0);
        checkOutput("t6_hold",     {31'd0, fetch_hold},   32'd0);
        checkOutput("t6_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("t6_wr_addr",  {24'd0, bus.wr_addr},  32'd0);
        checkOutput("t6_wr_data",  bus.wr_data,           32'd0);
        checkOutput("t6_done",     {31'd0, done},         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("t6_post_idle", {31'd0, busy}, 32'd0);

        // Start pulsed while busy is ignored
        $display("[TB] start ignored while busy");
        startLoad(8'h20, 8'd1);
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h32, 1'b0);
        start      = 1'b1;
        base_addr  = 8'h60;
        word_count = 8'd5;
        applyStimulus(8'h33, 1'b0);
        start = 1'b0;
        applyStimulus(8'h34, 1'b0);
        checkOutput("t7_wr_addr", {24'd0, bus.wr_addr}, 32'h20);
        checkOutput("t7_wr_data", bus.wr_data,          32'h34333231);
        nextCycle();
        checkOutput("t7_done",  {31'd0, done},          32'd1);
        checkOutput("t7_words", {24'd0, words_written}, 32'd1);
        nextCycle();
        checkOutput("t7_idle",  {31'd0, busy},          32'd0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction fetch path. Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory write port at consecutive PC-compatible addresses.
- Asserts fetch_hold while a load is in progress, so the PC and IF/ID stage do not fetch partially written program memory.

Parameters:
- ADDR_W, 8, width of instruction memory address (matches 8-bit PC)
- ADDR_STEP, 4, address increment per word written (byte-addressed PC, word-aligned)
- CNT_W, 8, width of word_count and words_written

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE from any state
- base_addr  in  ADDR_W  first word address, latched on accepted start
- word_count  in  CNT_W  number of words to load, latched on accepted start
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction memory write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  32  write data
- busy  out  1  state != IDLE
- fetch_hold  out  1  equals busy; freezes PC update and IF/ID capture
- done  out  1  one-cycle pulse on successful completion
- words_written  out  CNT_W  words written in the current or last load

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE; every output 0.
  - Internal cur_addr, words_left, byte_idx and assembly register cleared.
- States: IDLE, RECV, WRITE, DONE. Every output is registered or decoded from state only; there is no combinational path from in_valid to in_ready.
- IDLE:
  - in_ready=0.
  - On start=1: latch base_addr into cur_addr and word_count into words_left; clear words_written and byte_idx.
  - Next state is DONE if word_count==0, else RECV.
- RECV:
  - in_ready=1.
  - A byte is accepted when in_valid && in_ready. The byte goes to assembly bits [8*byte_idx+7 : 8*byte_idx], so the first byte is the LSB.
  - byte_idx 0..3. On the 4th accepted byte: go to WRITE, byte_idx returns to 0.
  - With no in_valid, remain in RECV indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - wr_en=1, wr_addr=cur_addr, wr_data=assembled word, in_ready=0.
  - On exit: cur_addr += ADDR_STEP (mod 2^ADDR_W, wraps 0xFC->0x00); words_left -= 1; words_written += 1.
  - Next state is DONE if words_left was 1, else RECV.
- DONE:
  - done=1 for one cycle, busy still 1.
  - Next state IDLE.
- Latency and throughput:
  - wr_en asserts in the cycle immediately after the 4th byte is accepted.
  - Minimum 5 cycles per word: 4 accept cycles plus 1 write cycle.
- start outside IDLE is ignored. start and abort high together in IDLE: abort wins, stay IDLE.
- Abort:
  - abort=1 in any state goes to IDLE next cycle. No done pulse, no further wr_en.
  - An abort in the WRITE cycle still completes that cycle's write, since wr_en is already asserted.
  - words_written keeps its value.
- Asynchronous reset mid-load: immediate return to IDLE, all outputs 0, partial word discarded.
- Bytes presented while in_ready=0 are not consumed. The source must hold them (standard valid/ready).
- word_count=0: IDLE -> DONE -> IDLE with no write and no in_ready.

Decomposition:
- Shared package (imem_pkg): ADDR_W, instruction width 32, ADDR_STEP, and the loader state enum (IDLE, RECV, WRITE, DONE).
- One natural sub-module: imem_word_packer. It holds byte_idx and the assembly register, takes byte accept strobes, and emits word_valid plus a 32-bit word. The FSM and address/count logic stay in imem_loader.

Test Plan:
- Single word: start with base=0x00, count=1; bytes 0x13,0x05,0x50,0x00 back-to-back -> wr_en one cycle after the 4th byte, wr_addr=0x00, wr_data=0x00500513; done one cycle later; words_written=1.
- Three words with a stalled source: in_valid toggled every other cycle, base=0x10 -> writes at 0x10, 0x14, 0x18; in_ready never high in WRITE cycles; fetch_hold high from the cycle after start until the return to IDLE.
- Address wrap: base=0xFC, count=2 -> writes at 0xFC then 0x00.
- Zero count: start with count=0 -> done pulse 1 cycle after start, no wr_en, in_ready stays 0.
- Abort after 2 bytes of word 2 (count=3) -> back to IDLE next cycle, no done, words_written=1. A following start/load of 1 word writes correctly, with no stale bytes in the word.
- Asynchronous reset: assert rst_n=0 mid-RECV between clock edges -> all outputs 0 immediately. start is ignored while busy.
